roce_rnr_retry_timer: RTL
=========================

Name: roce_rnr_retry_timer

Overview:
- Requester-side RNR (Receiver Not Ready) backoff engine for a single RC QP.
- Sits directly downstream of the RoCE ACK/AETH parser and consumes decoded ACK syndromes.
- On an RNR NAK it looks up the IB-defined RNR timer value from the 5-bit code and counts it down, stalling the TX path meanwhile. It then emits a retransmit request at the NAKed PSN, or flags an error once the retry budget is exhausted.

Parameters:
- CLOCK_PERIOD_PS, 3200, period of clk in ps. Sets the cycle counts in the internal RNR table.
- TIMER_W, 32, width of the countdown counter. Must hold the largest table entry.

Ports:
- clk  in  1  network clock
- rst_n  in  1  asynchronous active-low reset
- s_ack_valid  in  1  decoded ACK/NAK present
- s_ack_ready  out  1  accept; 1 at all times out of reset
- s_ack_syndrome  in  8  AETH syndrome: [6:5] 00=ACK, 01=RNR NAK, 11=NAK; [4:0]=RNR timer code
- s_ack_psn  in  24  PSN carried by the ACK/NAK
- cfg_rnr_retry  in  3  allowed RNR retries; 7 = infinite; sampled on each RNR NAK
- m_retry_valid  out  1  retransmit request
- m_retry_ready  in  1  TX scheduler accepts the request
- m_retry_psn  out  24  PSN to restart from
- rnr_wait  out  1  high in WAIT; TX must hold off new requests
- err_rnr_retry_exc  out  1  sticky: retry budget exceeded
- err_clear  in  1  clears the error and returns to IDLE

Behaviour:
- Reset values: s_ack_ready=0 while rst_n low, then 1. m_retry_valid=0, m_retry_psn=0, rnr_wait=0, err_rnr_retry_exc=0, rnr_cnt=0, timer=0, state=IDLE.
- RNR table: N[c] = floor(t_c[ns]*1000 / CLOCK_PERIOD_PS), computed at elaboration per IB Vol1 r1.4 RNR timer encoding.
  - Code 0 = 655.36 ms, code 1 = 0.01 ms, code 2 = 0.02 ms, …, code 31 = 491.52 ms.
  - At default: N[1]=3125, N[2]=6250, N[0]=204800000.
  - Any entry below 1 is forced to 1.
- Handshake: s_ack_* are transferred when s_ack_valid && s_ack_ready. m_retry_* follow valid/ready: m_retry_psn is stable while m_retry_valid=1, and m_retry_valid drops the cycle after acceptance.
- States: IDLE, WAIT, RETRY, ERROR.
- RNR NAK accepted in IDLE, WAIT or RETRY:
  - If cfg_rnr_retry != 7 and rnr_cnt == cfg_rnr_retry: go to ERROR, set err_rnr_retry_exc, drop m_retry_valid.
  - Otherwise: rnr_cnt += 1 (saturating at 7), latch psn, timer = N[code], go to WAIT.
  - A NAK arriving in WAIT restarts the timer with the new code. A NAK arriving in RETRY withdraws the pending request.
- WAIT: rnr_wait=1 and timer decrements by 1 each cycle.
  - When timer reaches 1 and decrements, go to RETRY.
  - m_retry_valid first goes high exactly N+1 cycles after the NAK acceptance edge.
- RETRY: m_retry_valid=1 and m_retry_psn=latched PSN. On m_retry_ready, go to IDLE. rnr_cnt is retained.
- Positive ACK (syndrome[6:5]=00) in IDLE, WAIT or RETRY: rnr_cnt=0 and go to IDLE; any pending wait or request is cancelled.
  - Simultaneous ACK and m_retry_ready in RETRY: the request is still considered delivered, and the state ends in IDLE.
- Fatal NAK (11) or reserved syndrome (10): consumed, no effect.
- ERROR:
  - All ACK inputs are consumed and ignored.
  - Exit only via err_clear (clears the flag, rnr_cnt=0, state=IDLE) or via reset.
  - err_clear in any other state only zeroes rnr_cnt.
- Reset mid-operation: state returns to IDLE immediately and asynchronously; any pending request is lost.

Optional Feature:
- Macro ROCE_RNR_STATS_EN.
- When defined, adds two outputs:
  - stat_rnr_nak_cnt [31:0]: counts accepted RNR NAKs.
  - stat_rnr_retry_cnt [31:0]: counts accepted m_retry handshakes.
  - Both saturate at 0xFFFFFFFF, reset to 0, and are unaffected by err_clear.
- When undefined, these ports and counters are absent and all other behaviour is identical.

Test Plan:
- cfg=3; RNR NAK code 1, PSN 0x000100, m_retry_ready=1 -> rnr_wait high 3125 cycles; m_retry_valid high at accept+3126 with PSN 0x000100, for one cycle.
- cfg=1; two RNR NAKs each fully retried -> first yields a retry; second sets err_rnr_retry_exc, no retry. err_clear -> flag 0, IDLE.
- RNR NAK code 2, then at cycle 100 of WAIT a positive ACK -> rnr_wait drops next cycle, no retry, rnr_cnt=0.
- RNR NAK code 2, then RNR NAK code 1 PSN 0x0000FF after 500 cycles -> retry at second accept+3126 with PSN 0x0000FF.
- In RETRY hold m_retry_ready=0 for 20 cycles -> valid and PSN stable; ready=1 -> one transfer. Then cfg=7 and 10 RNR NAKs -> no error.
- With ROCE_RNR_STATS_EN defined: 3 NAKs, 2 retries accepted -> stat_rnr_nak_cnt=3, stat_rnr_retry_cnt=2. Assert rst_n mid-WAIT -> all outputs return to reset values.

Source files
------------

// File: rtl/roce_rnr_retry_timer.sv
// roce_rnr_retry_timer: requester-side RNR NAK backoff engine for one RC QP.
// Decodes AETH syndromes and waits out the encoded RNR delay while stalling TX.
// It then requests a retransmit at the NAKed PSN, or raises a sticky error once
// the retry budget is spent.
// Optional macro ROCE_RNR_STATS_EN adds saturating RNR NAK / retry statistics.
`timescale 1ns/1ps
module roce_rnr_retry_timer #(
  parameter int unsigned CLOCK_PERIOD_PS = 3200,
  parameter int unsigned TIMER_W         = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_ack_valid,
  output logic        s_ack_ready,
  input  logic [7:0]  s_ack_syndrome,
  input  logic [23:0] s_ack_psn,
  input  logic [2:0]  cfg_rnr_retry,
  output logic        m_retry_valid,
  input  logic        m_retry_ready,
  output logic [23:0] m_retry_psn,
  output logic        rnr_wait,
  output logic        err_rnr_retry_exc,
  input  logic        err_clear
`ifdef ROCE_RNR_STATS_EN
  ,
  output logic [31:0] stat_rnr_nak_cnt,
  output logic [31:0] stat_rnr_retry_cnt
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_RETRY = 2'd2;
  localparam logic [1:0] ST_ERROR = 2'd3;

  localparam logic [1:0] SYN_ACK = 2'b00;
  localparam logic [1:0] SYN_RNR = 2'b01;

  localparam logic [2:0] CNT_MAX      = 3'd7;
  localparam logic [2:0] RETRY_INFINI = 3'd7;

  // RNR timer code -> delay in units of 10 us, converted to clk cycles (min 1)
  function automatic logic [TIMER_W-1:0] f_rnr_cycles(input logic [4:0] code);
    logic [63:0] units;
    logic [63:0] cyc;
    case (code)
      5'd0:  units = 64'd65536;
      5'd1:  units = 64'd1;
      5'd2:  units = 64'd2;
      5'd3:  units = 64'd3;
      5'd4:  units = 64'd4;
      5'd5:  units = 64'd6;
      5'd6:  units = 64'd8;
      5'd7:  units = 64'd12;
      5'd8:  units = 64'd16;
      5'd9:  units = 64'd24;
      5'd10: units = 64'd32;
      5'd11: units = 64'd48;
      5'd12: units = 64'd64;
      5'd13: units = 64'd96;
      5'd14: units = 64'd128;
      5'd15: units = 64'd192;
      5'd16: units = 64'd256;
      5'd17: units = 64'd384;
      5'd18: units = 64'd512;
      5'd19: units = 64'd768;
      5'd20: units = 64'd1024;
      5'd21: units = 64'd1536;
      5'd22: units = 64'd2048;
      5'd23: units = 64'd3072;
      5'd24: units = 64'd4096;
      5'd25: units = 64'd6144;
      5'd26: units = 64'd8192;
      5'd27: units = 64'd12288;
      5'd28: units = 64'd16384;
      5'd29: units = 64'd24576;
      5'd30: units = 64'd32768;
      default: units = 64'd49152;
    endcase
    cyc = (units * 64'd10_000_000) / 64'(CLOCK_PERIOD_PS);
    if (cyc == 64'd0) cyc = 64'd1;
    return TIMER_W'(cyc);
  endfunction

  logic [TIMER_W-1:0] w_rnr_tab [32];

  // Constant lookup table, one entry per RNR code
  for (genvar g = 0; g < 32; g++) begin : g_tab
    assign w_rnr_tab[g] = f_rnr_cycles(5'(g));
  end

  logic [1:0]         r_state;
  logic [2:0]         r_rnr_cnt;
  logic [TIMER_W-1:0] r_timer;
  logic [23:0]        r_psn;
  logic               r_err;
  logic               r_retry_valid;
  logic               r_rnr_wait;
  logic               r_ack_ready;

  logic [1:0]         w_state_nxt;
  logic [2:0]         w_cnt_nxt;
  logic [TIMER_W-1:0] w_timer_nxt;
  logic [23:0]        w_psn_nxt;
  logic               w_err_nxt;
  logic               w_rnr_acc;
  logic               w_ack_acc;
  logic               w_xfer;
  logic [1:0]         w_syn_type;
  logic               w_unused;

  assign w_ack_acc  = s_ack_valid & r_ack_ready;
  assign w_xfer     = r_retry_valid & m_retry_ready;
  assign w_syn_type = s_ack_syndrome[6:5];
  assign w_unused   = s_ack_syndrome[7];

  // Next-state: timer countdown, retry handshake, then ACK/NAK decode on top
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_rnr_cnt;
    w_timer_nxt = r_timer;
    w_psn_nxt   = r_psn;
    w_err_nxt   = r_err;
    w_rnr_acc   = 1'b0;
    case (r_state)
      ST_ERROR: begin
        if (err_clear) begin
          w_err_nxt   = 1'b0;
          w_cnt_nxt   = 3'd0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        if (r_state == ST_WAIT) begin
          if (r_timer <= TIMER_W'(1)) begin
            w_state_nxt = ST_RETRY;
            w_timer_nxt = '0;
          end else begin
            w_timer_nxt = r_timer - TIMER_W'(1);
          end
        end
        if ((r_state == ST_RETRY) && w_xfer) w_state_nxt = ST_IDLE;
        if (w_ack_acc) begin
          if (w_syn_type == SYN_ACK) begin
            w_cnt_nxt   = 3'd0;
            w_timer_nxt = '0;
            w_state_nxt = ST_IDLE;
          end else if (w_syn_type == SYN_RNR) begin
            w_rnr_acc = 1'b1;
            if ((cfg_rnr_retry != RETRY_INFINI) && (r_rnr_cnt == cfg_rnr_retry)) begin
              w_err_nxt   = 1'b1;
              w_timer_nxt = '0;
              w_state_nxt = ST_ERROR;
            end else begin
              w_cnt_nxt   = (r_rnr_cnt == CNT_MAX) ? CNT_MAX : r_rnr_cnt + 3'd1;
              w_psn_nxt   = s_ack_psn;
              w_timer_nxt = w_rnr_tab[s_ack_syndrome[4:0]];
              w_state_nxt = ST_WAIT;
            end
          end
        end
        if (err_clear) w_cnt_nxt = 3'd0;
      end
    endcase
  end

  // State and registered outputs; valid rises one cycle after entering RETRY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_rnr_cnt     <= 3'd0;
      r_timer       <= '0;
      r_psn         <= 24'd0;
      r_err         <= 1'b0;
      r_retry_valid <= 1'b0;
      r_rnr_wait    <= 1'b0;
      r_ack_ready   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_rnr_cnt     <= w_cnt_nxt;
      r_timer       <= w_timer_nxt;
      r_psn         <= w_psn_nxt;
      r_err         <= w_err_nxt;
      r_retry_valid <= (r_state == ST_RETRY) && (w_state_nxt == ST_RETRY);
      r_rnr_wait    <= (w_state_nxt == ST_WAIT);
      r_ack_ready   <= 1'b1;
    end
  end

  assign s_ack_ready       = r_ack_ready;
  assign m_retry_valid     = r_retry_valid;
  assign m_retry_psn       = r_psn;
  assign rnr_wait          = r_rnr_wait;
  assign err_rnr_retry_exc = r_err;

`ifdef ROCE_RNR_STATS_EN
  logic [31:0] r_stat_nak;
  logic [31:0] r_stat_retry;

  // Saturating statistics; only reset clears them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_nak   <= 32'd0;
      r_stat_retry <= 32'd0;
    end else begin
      if (w_rnr_acc && (r_stat_nak != 32'hFFFF_FFFF)) r_stat_nak <= r_stat_nak + 32'd1;
      if (w_xfer && (r_stat_retry != 32'hFFFF_FFFF)) r_stat_retry <= r_stat_retry + 32'd1;
    end
  end

  assign stat_rnr_nak_cnt   = r_stat_nak;
  assign stat_rnr_retry_cnt = r_stat_retry;
`endif

endmodule
